// File: rtl/ctrl_word_encoder_if.sv
// Handshake bundle between a control-word source/opcode consumer and ctrl_word_encoder.
// Ports: in_valid/in_ready/ctrl_word/imm_sel (input side), out_valid/out_ready/out_opcode (output side),
//        illegal pulse, fifo_count occupancy, err_count illegal-word counter.
interface ctrl_word_encoder_if #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [8:0]       ctrl_word;
    logic [1:0]       imm_sel;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_opcode;
    logic             illegal;
    logic [CW-1:0]    fifo_count;
    logic [ERR_W-1:0] err_count;

    // master: the environment driving control words and consuming opcodes
    modport master (
        output in_valid, ctrl_word, imm_sel, out_ready,
        input  in_ready, out_valid, out_opcode, illegal, fifo_count, err_count
    );

    // slave: the encoder itself
    modport slave (
        input  in_valid, ctrl_word, imm_sel, out_ready,
        output in_ready, out_valid, out_opcode, illegal, fifo_count, err_count
    );
endinterface

// File: rtl/ctrl_word_encoder.sv
// Purpose: rebuild 3-bit opcodes from 9-bit control words and queue them in a DEPTH-entry FIFO.
// Latency: one cycle from accepted legal word (empty FIFO) to out_valid/out_opcode; no comb in->out path.
// Backpressure: in_ready = !full (no same-cycle full bypass); illegal words are consumed but stall while full.
//
// Ports: clk, reset_n (async active-low), bus (ctrl_word_encoder_if.slave).
// Optional feature: define CTRL_ENC_ERRCNT_EN to build the saturating illegal-word counter (err_count);
// otherwise err_count is tied to zero.

// Generic FIFO with a registered head output that holds the last popped value when empty.
module ctrl_enc_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   push_rdy,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_count;
    logic [AW:0]      w_cnt_after_pop;
    logic [AW:0]      w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign w_full          = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty         = (r_wr_ptr == r_rd_ptr);
    assign w_do_push       = push_vld && !w_full;
    assign w_do_pop        = pop_rdy && !w_empty;
    assign w_count         = r_wr_ptr - r_rd_ptr;
    assign w_cnt_after_pop = w_count - (AW+1)'(w_do_pop);
    assign w_rd_next       = r_rd_ptr + (AW+1)'(w_do_pop);

    // Next head: the pushed word if it lands in an otherwise empty FIFO, else the entry
    // at the advanced read pointer; hold when the FIFO drains so the last value stays visible.
    always_comb begin
        w_head_next = r_head;
        if (w_do_push && (w_cnt_after_pop == '0)) begin
            w_head_next = push_dat;
        end else if (w_cnt_after_pop != '0) begin
            w_head_next = r_mem[w_rd_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
        end
    end

    assign push_rdy = !w_full;
    assign pop_vld  = !w_empty;
    assign pop_dat  = r_head;
    assign count    = w_count;
endmodule

module ctrl_word_encoder #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    ctrl_word_encoder_if.slave bus
);
    // Control word layout, MSB first:
    // {RegDst, MemToReg, MemWrite, Branch, MemRead, ALUOp[1:0], ALUSrc, RegWrite}
    localparam logic [8:0] CW_RTYPE = 9'b1_0_0_0_0_10_0_1;
    localparam logic [8:0] CW_ITYPE = 9'b0_0_0_0_0_11_1_1;
    localparam logic [8:0] CW_LW    = 9'b0_1_0_0_1_00_1_1;
    localparam logic [8:0] CW_SW    = 9'b0_0_1_0_0_00_1_0;
    localparam logic [8:0] CW_BNE   = 9'b0_0_0_1_0_01_0_0;

    logic                   w_legal;
    logic [2:0]             w_opcode;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_out_valid;
    logic [2:0]             w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   r_illegal;

    always_comb begin
        w_legal  = 1'b1;
        w_opcode = 3'b000;
        case (bus.ctrl_word)
            CW_RTYPE: w_opcode = 3'b000;
            // andi/ori/addi/slti occupy opcodes 001..100 in imm_sel order
            CW_ITYPE: w_opcode = {1'b0, bus.imm_sel} + 3'd1;
            CW_LW:    w_opcode = 3'b101;
            CW_SW:    w_opcode = 3'b110;
            CW_BNE:   w_opcode = 3'b111;
            default:  w_legal  = 1'b0;
        endcase
    end

    // Illegal words complete the handshake but never reach the FIFO.
    assign w_accept = bus.in_valid && w_in_ready;
    assign w_push   = w_accept && w_legal;

    ctrl_enc_fifo #(
        .WIDTH (3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (w_push),
        .push_dat (w_opcode),
        .push_rdy (w_in_ready),
        .pop_vld  (w_out_valid),
        .pop_rdy  (bus.out_ready),
        .pop_dat  (w_head),
        .count    (w_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
        end
    end

`ifdef CTRL_ENC_ERRCNT_EN
    logic [ERR_W-1:0] r_err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (w_accept && !w_legal && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = {ERR_W{1'b0}};
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_opcode = w_head;
    assign bus.illegal    = r_illegal;
    assign bus.fifo_count = w_count;
endmodule

// File: tb/tb_ctrl_word_encoder.sv
// Self-checking bench for ctrl_word_encoder: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the opcode stream.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_ctrl_word_encoder;
    localparam int DEPTH = 4;
    localparam int ERR_W = 8;

    logic clk;
    logic reset_n;

    ctrl_word_encoder_if #(.DEPTH(DEPTH), .ERR_W(ERR_W)) bus();

    ctrl_word_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         q[$];
    logic [2:0] m_out;
    bit         m_ill;
    int         m_err;

    // Field-level decode of a control word into its opcode; -1 when no instruction matches.
    function automatic int ref_encode(logic [8:0] w, logic [1:0] sel);
        logic       reg_dst, mem_to_reg, mem_write, branch, mem_read, alu_src, reg_write;
        logic [1:0] alu_op;
        {reg_dst, mem_to_reg, mem_write, branch, mem_read, alu_op, alu_src, reg_write} = w;
        if ({mem_to_reg, mem_write, branch, mem_read, alu_src} == 5'b0 && reg_dst && reg_write && alu_op == 2'd2)
            return 0;
        if ({reg_dst, mem_to_reg, mem_write, branch, mem_read} == 5'b0 && alu_op == 2'd3 && alu_src && reg_write)
            return 1 + int'(sel);
        if (!reg_dst && mem_to_reg && !mem_write && !branch && mem_read && alu_op == 2'd0 && alu_src && reg_write)
            return 5;
        if (!reg_dst && !mem_to_reg && mem_write && !branch && !mem_read && alu_op == 2'd0 && alu_src && !reg_write)
            return 6;
        if ({reg_dst, mem_to_reg, mem_write, mem_read, alu_src, reg_write} == 6'b0 && branch && alu_op == 2'd1)
            return 7;
        return -1;
    endfunction

    // Legal word patterns, built from the field table: R, I, lw, sw, bne.
    function automatic logic [8:0] pick_word(int k);
        case (k)
            0:       return 9'b100001001;
            1:       return 9'b000001111;
            2:       return 9'b010010011;
            3:       return 9'b001000010;
            default: return 9'b000100100;
        endcase
    endfunction

    function automatic int exp_err();
`ifdef CTRL_ENC_ERRCNT_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    // Advance one clock with the inputs currently driven and update the model.
    task automatic tick();
        bit acc, pop;
        int op, popped;
        acc = bus.in_valid && (q.size() < DEPTH);
        pop = bus.out_ready && (q.size() > 0);
        op  = ref_encode(bus.ctrl_word, bus.imm_sel);
        @(posedge clk);
        if (pop) begin
            popped = q.pop_front();
            m_out  = 3'(popped);
        end
        if (acc && op >= 0) q.push_back(op);
        if (q.size() > 0) m_out = 3'(q[0]);
        m_ill = acc && (op < 0);
        if (acc && op < 0 && m_err < 255) m_err++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_out = 3'd0;
        m_ill = 1'b0;
        m_err = 0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.ctrl_word = 9'd0;
        bus.imm_sel   = 2'd0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_opcode !== 3'd0) begin errors++; $display("FAIL reset_opcode got %0d want 0", bus.out_opcode); end
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", bus.illegal); end
        checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
    endtask

    task automatic test_rtype();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ctrl_word = pick_word(0);
        bus.imm_sel   = 2'($urandom_range(0, 3));
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rtype_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_opcode !== 3'b000) begin errors++; $display("FAIL rtype_opcode got %b want 000", bus.out_opcode); end
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL rtype_count got %0d want 1", bus.fifo_count); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rtype_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_itype();
        bus.out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.in_valid  = 1'b1;
            bus.ctrl_word = pick_word(1);
            bus.imm_sel   = 2'(s);
            tick();
            checks++;
            if (bus.out_opcode !== 3'(s + 1) || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL itype_sel%0d got op=%b vld=%b want op=%b vld=1", s, bus.out_opcode, bus.out_valid, 3'(s + 1));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL itype_drain got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_mem_branch();
        logic [2:0] exp_ops [3];
        exp_ops[0] = 3'b101; exp_ops[1] = 3'b110; exp_ops[2] = 3'b111;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid  = 1'b1;
            bus.ctrl_word = pick_word(2 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL mem_count got %0d want 3", bus.fifo_count); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.out_opcode !== exp_ops[k]) begin
                errors++; $display("FAIL mem_order%0d got %b want %b", k, bus.out_opcode, exp_ops[k]);
            end
            tick();
        end
        checks++; if (bus.out_opcode !== 3'b111 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mem_hold got op=%b vld=%b want op=111 vld=0", bus.out_opcode, bus.out_valid);
        end
    endtask

    task automatic test_full_wrap();
        logic [2:0] exp_ops [5];
        int op;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid  = 1'b1;
            bus.ctrl_word = pick_word(int'($urandom_range(0, 4)));
            bus.imm_sel   = 2'($urandom_range(0, 3));
            op            = ref_encode(bus.ctrl_word, bus.imm_sel);
            exp_ops[k]    = 3'(op);
            if (k < 4) tick();
        end
        checks++; if (bus.in_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
            errors++; $display("FAIL full_state got rdy=%b cnt=%0d want rdy=0 cnt=4", bus.in_ready, bus.fifo_count);
        end
        repeat (2) tick();
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_hold got %0d want 4", bus.fifo_count); end
        checks++; if (bus.out_opcode !== exp_ops[0]) begin errors++; $display("FAIL full_head got %b want %b", bus.out_opcode, exp_ops[0]); end
        // Pop while full: 5th word must not slip in on the same edge.
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.fifo_count !== 3'd3 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL full_nobypass got cnt=%0d rdy=%b want cnt=3 rdy=1", bus.fifo_count, bus.in_ready);
        end
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_accept5 got %0d want 4", bus.fifo_count); end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (bus.out_opcode !== exp_ops[k]) begin
                errors++; $display("FAIL wrap_order%0d got %b want %b", k, bus.out_opcode, exp_ops[k]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ctrl_word = pick_word(2);
        tick();
        bus.ctrl_word = 9'b111111111;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse got %b want 1", bus.illegal); end
        checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL illegal_count got %0d want 1", bus.fifo_count); end
        tick();
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle got %b want 0", bus.illegal); end
        // Fill, then offer an illegal word: it must stall (no pulse) while full.
        bus.in_valid  = 1'b1;
        bus.ctrl_word = pick_word(0);
        repeat (3) tick();
        bus.ctrl_word = 9'b111111111;
        repeat (2) tick();
        checks++; if (bus.illegal !== m_ill || m_ill) begin errors++; $display("FAIL illegal_full_stall got %b want 0", bus.illegal); end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_err_count();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ctrl_word = 9'b111111111;
        repeat (260) tick();
        bus.in_valid = 1'b0;
        checks++; if (int'(bus.err_count) !== exp_err()) begin
            errors++; $display("FAIL err_count_sat got %0d want %0d", bus.err_count, exp_err());
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            // Source holds a stalled word stable until it is taken.
            if (!(bus.in_valid && q.size() >= DEPTH)) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.ctrl_word = ($urandom_range(0, 3) == 0) ? 9'($urandom) : pick_word(int'($urandom_range(0, 4)));
                bus.imm_sel   = 2'($urandom_range(0, 3));
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (bus.out_valid !== (q.size() > 0) || bus.fifo_count !== 3'(q.size()) ||
                bus.out_opcode !== m_out || bus.illegal !== m_ill ||
                bus.in_ready !== (q.size() < DEPTH) || int'(bus.err_count) !== exp_err()) begin
                errors++;
                $display("FAIL random_c%0d got vld=%b cnt=%0d op=%b ill=%b rdy=%b err=%0d want vld=%b cnt=%0d op=%b ill=%b rdy=%b err=%0d",
                         c, bus.out_valid, bus.fifo_count, bus.out_opcode, bus.illegal, bus.in_ready, bus.err_count,
                         q.size() > 0, q.size(), m_out, m_ill, q.size() < DEPTH, exp_err());
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.ctrl_word = pick_word(k + 2);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL areset_pre got %0d want 3", bus.fifo_count); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_now got vld=%b cnt=%0d rdy=%b want vld=0 cnt=0 rdy=1", bus.out_valid, bus.fifo_count, bus.in_ready);
        end
        checks++; if (bus.out_opcode !== 3'd0 || bus.err_count !== 8'd0) begin
            errors++; $display("FAIL areset_regs got op=%b err=%0d want op=0 err=0", bus.out_opcode, bus.err_count);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_mem_branch();
        test_full_wrap();
        test_illegal();
        test_err_count();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
